// File: rtl/instruction_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | instruction_fetch_stage: PC owner, handshaked imem fetch, IF/ID register.  |
// | Optional IF_PERF_CNT_EN adds the fetch_stall_cycles counter.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instruction_fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [31:0] if_id_instr,
  output logic [63:0] if_id_pc,
  output logic        if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] pc;
  logic [63:0] pc_nxt;
  logic [63:0] drop_addr;
  logic [63:0] drop_addr_nxt;
  logic [31:0] hold_instr;
  logic [31:0] hold_instr_nxt;
  logic [63:0] hold_pc;
  logic [63:0] hold_pc_nxt;
  logic [31:0] instr_nxt;
  logic [63:0] ipc_nxt;
  logic        valid_nxt;
  logic [63:0] pc_plus4;
  logic [63:0] redirect_tgt;

  assign pc_plus4     = pc + 64'd4;
  assign redirect_tgt = {redirect_pc[63:2], 2'b00};

  // DROP keeps presenting the abandoned address until memory completes it.
  assign imem_req  = (state != ST_HOLD);
  assign imem_addr = (state == ST_DROP) ? drop_addr : pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      drop_addr   <= 64'd0;
      hold_instr  <= 32'd0;
      hold_pc     <= 64'd0;
      if_id_instr <= 32'd0;
      if_id_pc    <= 64'd0;
      if_id_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      drop_addr   <= drop_addr_nxt;
      hold_instr  <= hold_instr_nxt;
      hold_pc     <= hold_pc_nxt;
      if_id_instr <= instr_nxt;
      if_id_pc    <= ipc_nxt;
      if_id_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    drop_addr_nxt  = drop_addr;
    hold_instr_nxt = hold_instr;
    hold_pc_nxt    = hold_pc;
    instr_nxt      = if_id_instr;
    ipc_nxt        = if_id_pc;
    valid_nxt      = if_id_valid;

    if (redirect) begin
      pc_nxt    = redirect_tgt;
      valid_nxt = 1'b0;
      // An unanswered request cannot be withdrawn; wait out its ack in DROP.
      if (state == ST_FETCH && !imem_ack) begin
        state_nxt     = ST_DROP;
        drop_addr_nxt = pc;
      end else if (state == ST_DROP && !imem_ack) begin
        state_nxt = ST_DROP;
      end else begin
        state_nxt = ST_FETCH;
      end
    end else begin
      unique case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            pc_nxt = pc_plus4;
            if (flush) begin
              valid_nxt = 1'b0;
            end else if (stall) begin
              hold_instr_nxt = imem_rdata;
              hold_pc_nxt    = pc;
              state_nxt      = ST_HOLD;
            end else begin
              instr_nxt = imem_rdata;
              ipc_nxt   = pc;
              valid_nxt = 1'b1;
            end
          end else if (flush || !stall) begin
            valid_nxt = 1'b0;
          end
        end
        ST_HOLD: begin
          if (flush) begin
            valid_nxt = 1'b0;
            state_nxt = ST_FETCH;
          end else if (!stall) begin
            instr_nxt = hold_instr;
            ipc_nxt   = hold_pc;
            valid_nxt = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
        ST_DROP: begin
          if (imem_ack) begin
            state_nxt = ST_FETCH;
          end
          if (flush || !stall) begin
            valid_nxt = 1'b0;
          end
        end
        default: begin
          state_nxt = ST_FETCH;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic        stall_cycle;

  assign stall_cycle = (imem_req && !imem_ack) || (state == ST_HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (stall_cycle && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign fetch_stall_cycles = stall_cnt;
`else
  // Stall telemetry is not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for instruction_fetch_stage: directed test-plan scenarios then random traffic,
// checked against a transaction-level model of the fetch rules.
module tb_instruction_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] if_id_instr;
  logic [63:0] if_id_pc;
  logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_stall_cycles;
`endif

  instruction_fetch_stage #(.RESET_PC(64'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_stall_cycles (fetch_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // memory model state
  int mem_lat = 0;
  int wait_cnt = 0;
  bit rand_lat = 0;
  logic        obs_req;
  logic [63:0] obs_addr;

  // reference model state
  logic [63:0] m_pc;
  bit          m_hold;
  logic [31:0] m_hold_instr;
  logic [63:0] m_hold_pc;
  bit          m_drop;
  logic [63:0] m_drop_addr;
  logic [31:0] m_instr;
  logic [63:0] m_ipc;
  bit          m_valid;
  logic [31:0] m_cnt;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[31:2], 2'b01} ^ 32'hC3A5_0F1E ^ a[63:32];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'h0; m_hold = 0; m_hold_instr = '0; m_hold_pc = '0;
    m_drop = 0; m_drop_addr = '0; m_instr = '0; m_ipc = '0; m_valid = 0; m_cnt = '0;
    wait_cnt = 0;
  endtask

  task automatic model_update(input logic ack, input logic st, input logic fl,
                              input logic rd, input logic [63:0] rpc);
    logic        req;
    logic [31:0] word;
    req = !m_hold;
    if (((req && !ack) || m_hold) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (rd) begin
      if (req && !ack && !m_drop) m_drop_addr = m_pc;
      m_drop  = req && !ack;
      m_hold  = 0;
      m_pc    = {rpc[63:2], 2'b00};
      m_valid = 0;
    end else if (m_drop) begin
      if (ack) m_drop = 0;
      if (fl || !st) m_valid = 0;
    end else if (m_hold) begin
      if (fl) begin
        m_valid = 0; m_hold = 0;
      end else if (!st) begin
        m_instr = m_hold_instr; m_ipc = m_hold_pc; m_valid = 1; m_hold = 0;
      end
    end else if (ack) begin
      word = mem_word(m_pc);
      if (fl) m_valid = 0;
      else if (st) begin
        m_hold = 1; m_hold_instr = word; m_hold_pc = m_pc;
      end else begin
        m_instr = word; m_ipc = m_pc; m_valid = 1;
      end
      m_pc = m_pc + 64'd4;
    end else if (fl || !st) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input logic st, input logic fl, input logic rd, input logic [63:0] rpc);
    logic ack;
    @(negedge clk);
    obs_req  = imem_req;
    obs_addr = imem_addr;
    chk("imem_req", imem_req, !m_hold);
    if (!m_hold) chk("imem_addr", imem_addr, m_drop ? m_drop_addr : m_pc);
    ack = 1'b0;
    imem_rdata = $urandom;
    if (imem_req) begin
      if (wait_cnt >= mem_lat) begin
        ack = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wait_cnt = 0;
        if (rand_lat) mem_lat = $urandom_range(0, 3);
      end else begin
        wait_cnt++;
      end
    end
    imem_ack = ack; stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    #1;
    model_update(ack, st, fl, rd, rpc);
    chk("if_id_valid", if_id_valid, m_valid);
    chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_instr", if_id_instr, m_instr);
`ifdef IF_PERF_CNT_EN
    chk("fetch_stall_cycles", fetch_stall_cycles, m_cnt);
`endif
    imem_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; imem_ack = 0; imem_rdata = 0; stall = 0; flush = 0;
    redirect = 0; redirect_pc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk("reset_valid", if_id_valid, 1'b0);
    chk("reset_pc", if_id_pc, 64'h0);
    chk("reset_instr", if_id_instr, 32'h0);

    // zero-wait streaming
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 64'h0);
      chk("stream_pc", if_id_pc, 64'(4 * i));
      chk("stream_valid", if_id_valid, 1'b1);
    end

    // stall across an ack at 0x8
    step(0, 0, 1, 64'h4);
    step(0, 0, 0, 64'h0);
    chk("pre_stall_pc", if_id_pc, 64'h4);
    step(1, 0, 0, 64'h0);
    chk("stall1_pc", if_id_pc, 64'h4);
    step(1, 0, 0, 64'h0);
    chk("hold_req", obs_req, 1'b0);
    chk("stall2_pc", if_id_pc, 64'h4);
    step(1, 0, 0, 64'h0);
    chk("stall3_pc", if_id_pc, 64'h4);
    step(0, 0, 0, 64'h0);
    chk("release_pc", if_id_pc, 64'h8);
    chk("release_valid", if_id_valid, 1'b1);
    step(0, 0, 0, 64'h0);
    chk("after_release_addr", obs_addr, 64'hC);

    // redirect while a 2-cycle request to 0x10 is outstanding
    mem_lat = 2;
    step(0, 0, 1, 64'h1003);
    chk("redir_addr_old", obs_addr, 64'h10);
    step(0, 0, 0, 64'h0);
    step(0, 0, 0, 64'h0);
    chk("drop_valid", if_id_valid, 1'b0);
    step(0, 0, 0, 64'h0);
    chk("redir_new_addr", obs_addr, 64'h1000);
    step(0, 0, 0, 64'h0);
    step(0, 0, 0, 64'h0);
    chk("redir_first_pc", if_id_pc, 64'h1000);
    chk("redir_first_valid", if_id_valid, 1'b1);

    // flush coincident with an ack at 0x20
    mem_lat = 0;
    step(0, 0, 1, 64'h20);
    step(0, 1, 0, 64'h0);
    chk("flush_valid", if_id_valid, 1'b0);
    step(0, 0, 0, 64'h0);
    chk("flush_next_addr", obs_addr, 64'h24);

    // PC wrap
    step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    step(0, 0, 0, 64'h0);
    chk("wrap_pc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 64'h0);
    chk("wrap_addr", obs_addr, 64'h0);

    // asynchronous reset between edges
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_valid", if_id_valid, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    step(0, 0, 0, 64'h0);
    chk("restart_addr", obs_addr, 64'h0);

`ifdef IF_PERF_CNT_EN
    @(negedge clk);
    reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    mem_lat = 5;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 64'h0);
    step(1, 0, 0, 64'h0);
    step(1, 0, 0, 64'h0);
    mem_lat = 0;
    step(0, 0, 0, 64'h0);
    chk("perf_cnt_7", fetch_stall_cycles, 32'd7);
`endif

    // random traffic
    rand_lat = 1;
    for (int i = 0; i < 800; i++) begin
      logic        st;
      logic        fl;
      logic        rd;
      logic [63:0] rpc;
      st  = ($urandom_range(0, 99) < 25);
      fl  = ($urandom_range(0, 99) < 8);
      rd  = ($urandom_range(0, 99) < 7);
      rpc = {$urandom, $urandom};
      step(st, fl, rd, rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
